amber_trace_buf: RTL and testbench
==================================

# amber_trace_buf

Synthesizable pipeline trace buffer for the amber core that replaces per-tick simulation printouts with on-chip capture. Every clock in a capturing state it stores one entry: the PC and opcode of every monitored pipeline stage plus a free-running tick stamp. Capture can be free-running, or stopped a programmable number of entries after a PC or opcode trigger in a chosen stage. It sits beside the core, fed from the inter-stage PC/opcode wires, and is read out through a registered random-access port.

## Interface
- NSTG, 7, number of monitored stages (IA..WB)
- PC_W, 24, PC width per stage
- OPC_W, 8, opcode width per stage
- DEPTH, 32, entries; power of two, ≥4
- TICK_W, 16, tick stamp width
- iw_clk  in  1  clock; all logic on rising edge
- iw_rst  in  1  asynchronous, active-high reset
- iw_pc_bus  in  NSTG*PC_W  stage PCs; stage s at bits [s*PC_W +: PC_W]
- iw_opc_bus  in  NSTG*OPC_W  stage opcodes, same packing
- iw_arm  in  1  pulse: clear buffer, start capture
- iw_stop  in  1  pulse: force capture end
- iw_mode  in  2  0 free-run, 1 PC trigger, 2 opcode trigger, 3 reserved (behaves as 0)
- iw_trig_stg  in  clog2(NSTG)  stage compared for trigger
- iw_trig_pc  in  PC_W  trigger PC value
- iw_trig_opc  in  OPC_W  trigger opcode value
- iw_post  in  clog2(DEPTH)  entries to record after the trigger entry
- iw_rd_idx  in  clog2(DEPTH)  read index, 0 = oldest valid entry
- iw_rd_stg  in  clog2(NSTG)  stage selected for read
- ow_rd_pc  out  PC_W  PC of selected entry/stage
- ow_rd_opc  out  OPC_W  opcode of selected entry/stage
- ow_rd_tick  out  TICK_W  tick stamp of selected entry
- ow_state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
- ow_count  out  clog2(DEPTH)+1  valid entries, saturates at DEPTH
- ow_trig_idx  out  clog2(DEPTH)  relative index of the trigger entry (valid in DONE after a trigger)
- ow_tick  out  TICK_W  current tick counter

## Operation
- Tick counter: increments every cycle from reset in all states and wraps at 2^TICK_W.
- IDLE: no writes. iw_arm → ARMED.
- On arm, in any state: wr_ptr=0, count=0, trigger flag cleared; next state ARMED. Arm has priority over stop and over a trigger in the same cycle.
- ARMED: each cycle, write {all PCs, all opcodes, tick} at wr_ptr. wr_ptr increments mod DEPTH and count saturates at DEPTH (oldest entry overwritten).
- Trigger, ARMED only: mode 1 fires when PC[iw_trig_stg]==iw_trig_pc; mode 2 fires when OPC[iw_trig_stg]==iw_trig_opc. The compare uses the same-cycle inputs.
- When the trigger fires, the entry written that cycle is the trigger entry, and trig_ptr=wr_ptr.
  - iw_post==0 → DONE.
  - Otherwise remaining=iw_post → POST.
- POST: write each cycle and decrement remaining. The write that brings remaining to 0 → DONE. Exactly iw_post entries follow the trigger entry.
- iw_stop in ARMED/POST → DONE. That cycle's entry is still written. Stop in IDLE/DONE has no effect.
- DONE: no writes; contents frozen until the next arm.
- Read address = (wr_ptr − count + iw_rd_idx) mod DEPTH. An index ≥ count returns stale data; this is not an error.
- ow_trig_idx = (trig_ptr − (wr_ptr − count)) mod DEPTH, computed when entering DONE. It is 0 if no trigger occurred.
- Trigger inputs and iw_post are sampled only on the trigger cycle. Mode changes mid-capture take effect next cycle.

## Timing
- Reset: ow_state=0, ow_count=0, ow_trig_idx=0, ow_tick=0, ow_rd_*=0, internal pointers 0. Buffer RAM is not cleared.
- The first entry is written on the cycle after the iw_arm edge. The arm cycle itself is not captured.
- ow_state and ow_count update at the edge that performs the write.
- Read: registered, 1-cycle latency from iw_rd_idx/iw_rd_stg. Reading while writing returns pre-write RAM contents.
- Reset asserted mid-capture: immediate return to IDLE, all outputs to reset values.

## Test plan
- Reset, then arm with mode 0 and drive PC[0]=cycle number for 40 cycles, then stop.
  - Expect count=32 and state=3.
  - idx 0 returns PC 9, idx 31 returns PC 40.
  - Tick stamps are consecutive.
- Mode 1, trig_stg=4, trig_pc=0x000123, post=5. PC[4]=0x000123 appears 20 cycles after arm.
  - State reaches 3 exactly 5 cycles after the trigger.
  - Entry at ow_trig_idx holds 0x000123.
  - count=26.
- Mode 2, trig_opc=0x2A, post=0: opcode 0x2A appears on the 3rd captured cycle.
  - DONE on that edge.
  - count=3, trig_idx=2.
- Arm and trigger in the same cycle: arm wins, state=1 with count=0, and the trigger is ignored until the next cycle.
- Assert iw_rst during POST: state=0 and ow_tick=0 immediately. Re-arm works normally.
- Tick wrap with TICK_W=4: stamps run …14,15,0,1 across consecutive entries.

Source files
------------

// File: rtl/amber_trace_buf_if.sv
// amber_trace_buf_if: capture, trigger and readout bundle
// master drives stage wires/controls, slave is the buffer
interface amber_trace_buf_if #(
  parameter int NSTG   = 7,
  parameter int PC_W   = 24,
  parameter int OPC_W  = 8,
  parameter int DEPTH  = 32,
  parameter int TICK_W = 16
) ();
  localparam int SW = $clog2(NSTG);
  localparam int AW = $clog2(DEPTH);

  logic [NSTG*PC_W-1:0]  iw_pc_bus;
  logic [NSTG*OPC_W-1:0] iw_opc_bus;
  logic                  iw_arm;
  logic                  iw_stop;
  logic [1:0]            iw_mode;
  logic [SW-1:0]         iw_trig_stg;
  logic [PC_W-1:0]       iw_trig_pc;
  logic [OPC_W-1:0]      iw_trig_opc;
  logic [AW-1:0]         iw_post;
  logic [AW-1:0]         iw_rd_idx;
  logic [SW-1:0]         iw_rd_stg;
  logic [PC_W-1:0]       ow_rd_pc;
  logic [OPC_W-1:0]      ow_rd_opc;
  logic [TICK_W-1:0]     ow_rd_tick;
  logic [1:0]            ow_state;
  logic [AW:0]           ow_count;
  logic [AW-1:0]         ow_trig_idx;
  logic [TICK_W-1:0]     ow_tick;

  modport master (
    output iw_pc_bus, iw_opc_bus, iw_arm, iw_stop,
    output iw_mode, iw_trig_stg, iw_trig_pc, iw_trig_opc,
    output iw_post, iw_rd_idx, iw_rd_stg,
    input  ow_rd_pc, ow_rd_opc, ow_rd_tick,
    input  ow_state, ow_count, ow_trig_idx, ow_tick
  );

  modport slave (
    input  iw_pc_bus, iw_opc_bus, iw_arm, iw_stop,
    input  iw_mode, iw_trig_stg, iw_trig_pc, iw_trig_opc,
    input  iw_post, iw_rd_idx, iw_rd_stg,
    output ow_rd_pc, ow_rd_opc, ow_rd_tick,
    output ow_state, ow_count, ow_trig_idx, ow_tick
  );
endinterface

// File: rtl/amber_trace_buf.sv
// amber_trace_buf: on-chip pipeline PC/opcode trace capture
// free-run or PC/opcode trigger with post-trigger depth
module amber_trace_buf #(
  parameter int NSTG   = 7,
  parameter int PC_W   = 24,
  parameter int OPC_W  = 8,
  parameter int DEPTH  = 32,
  parameter int TICK_W = 16
) (
  input logic iw_clk,
  input logic iw_rst,
  amber_trace_buf_if.slave bus
);
  localparam int SW = $clog2(NSTG);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [SW-1:0] LAST_STG = SW'(NSTG - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [TICK_W-1:0] tick_q;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [AW-1:0]     trig_ptr_q;
  logic [AW-1:0]     remain_q;
  logic [AW-1:0]     trig_idx_q, trig_idx_d;
  logic              trig_q;
  logic              hit, fire, we, done_entry;
  logic [AW-1:0]     rd_addr;

  logic [PC_W-1:0]  pc_stg  [NSTG];
  logic [OPC_W-1:0] opc_stg [NSTG];
  logic [PC_W-1:0]  sel_pc;
  logic [OPC_W-1:0] sel_opc;

  logic [PC_W-1:0]   mem_pc   [DEPTH][NSTG];
  logic [OPC_W-1:0]  mem_opc  [DEPTH][NSTG];
  logic [TICK_W-1:0] mem_tick [DEPTH];

  logic [PC_W-1:0]   rd_pc_q;
  logic [OPC_W-1:0]  rd_opc_q;
  logic [TICK_W-1:0] rd_tick_q;

  // unpack the flat stage buses
  always_comb begin
    for (int s = 0; s < NSTG; s++) begin
      pc_stg[s]  = bus.iw_pc_bus[s*PC_W +: PC_W];
      opc_stg[s] = bus.iw_opc_bus[s*OPC_W +: OPC_W];
    end
  end

  // pick the stage being watched by the trigger
  always_comb begin
    sel_pc  = '0;
    sel_opc = '0;
    if (bus.iw_trig_stg <= LAST_STG) begin
      sel_pc  = pc_stg[bus.iw_trig_stg];
      sel_opc = opc_stg[bus.iw_trig_stg];
    end
  end

  // trigger compare on same-cycle inputs
  always_comb begin
    hit = 1'b0;
    unique case (bus.iw_mode)
      2'd1:    hit = (sel_pc == bus.iw_trig_pc);
      2'd2:    hit = (sel_opc == bus.iw_trig_opc);
      default: hit = 1'b0;
    endcase
  end

  assign fire = hit && (state_q == ARMED) && !bus.iw_arm;

  // state register
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state; arm overrides stop and trigger
  always_comb begin
    state_d = state_q;
    if (bus.iw_arm) begin
      state_d = ARMED;
    end else begin
      unique case (state_q)
        IDLE:  state_d = IDLE;
        ARMED: begin
          if (bus.iw_stop)
            state_d = DONE;
          else if (fire)
            state_d = (bus.iw_post == '0) ? DONE : POST;
        end
        POST: begin
          if (bus.iw_stop || remain_q == AW'(1))
            state_d = DONE;
        end
        DONE:  state_d = DONE;
      endcase
    end
  end

  // write enable, pointer/count update, trigger index
  always_comb begin
    we       = !bus.iw_arm &&
               (state_q == ARMED || state_q == POST);
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.iw_arm) begin
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (we) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (count_q != FULL) count_d = count_q + CW'(1);
    end
    done_entry = (state_d == DONE) && (state_q != DONE);
    trig_idx_d = '0;
    if (fire)
      trig_idx_d = wr_ptr_q - (wr_ptr_d - count_d[AW-1:0]);
    else if (trig_q)
      trig_idx_d = trig_ptr_q - (wr_ptr_d - count_d[AW-1:0]);
  end

  // capture bookkeeping and free-running tick
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      tick_q     <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      trig_ptr_q <= '0;
      remain_q   <= '0;
      trig_idx_q <= '0;
      trig_q     <= 1'b0;
    end else begin
      tick_q   <= tick_q + TICK_W'(1);
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (bus.iw_arm) begin
        trig_q <= 1'b0;
      end else if (fire) begin
        trig_q     <= 1'b1;
        trig_ptr_q <= wr_ptr_q;
        remain_q   <= bus.iw_post;
      end else if (state_q == POST) begin
        remain_q <= remain_q - AW'(1);
      end
      if (done_entry) trig_idx_q <= trig_idx_d;
    end
  end

  // trace RAM write port, contents survive reset
  always_ff @(posedge iw_clk) begin
    if (we) begin
      for (int s = 0; s < NSTG; s++) begin
        mem_pc[wr_ptr_q][s]  <= pc_stg[s];
        mem_opc[wr_ptr_q][s] <= opc_stg[s];
      end
      mem_tick[wr_ptr_q] <= tick_q;
    end
  end

  assign rd_addr = wr_ptr_q - count_q[AW-1:0] + bus.iw_rd_idx;

  // registered read port relative to oldest entry
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      rd_pc_q   <= '0;
      rd_opc_q  <= '0;
      rd_tick_q <= '0;
    end else begin
      rd_tick_q <= mem_tick[rd_addr];
      if (bus.iw_rd_stg <= LAST_STG) begin
        rd_pc_q  <= mem_pc[rd_addr][bus.iw_rd_stg];
        rd_opc_q <= mem_opc[rd_addr][bus.iw_rd_stg];
      end else begin
        rd_pc_q  <= '0;
        rd_opc_q <= '0;
      end
    end
  end

  assign bus.ow_rd_pc    = rd_pc_q;
  assign bus.ow_rd_opc   = rd_opc_q;
  assign bus.ow_rd_tick  = rd_tick_q;
  assign bus.ow_state    = state_q;
  assign bus.ow_count    = count_q;
  assign bus.ow_trig_idx = trig_idx_q;
  assign bus.ow_tick     = tick_q;
endmodule

// File: tb/tb_amber_trace_buf.sv
// tb_amber_trace_buf: directed + random capture runs
// checked against a queue-based trace model
`timescale 1ns/1ps
module tb_amber_trace_buf;
  localparam int NSTG  = 7;
  localparam int PC_W  = 24;
  localparam int OPC_W = 8;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  amber_trace_buf_if #(.NSTG(NSTG), .PC_W(PC_W), .OPC_W(OPC_W),
    .DEPTH(DEPTH), .TICK_W(16)) bus ();
  amber_trace_buf_if #(.NSTG(NSTG), .PC_W(PC_W), .OPC_W(OPC_W),
    .DEPTH(DEPTH), .TICK_W(4)) bus4 ();

  assign bus4.iw_pc_bus   = bus.iw_pc_bus;
  assign bus4.iw_opc_bus  = bus.iw_opc_bus;
  assign bus4.iw_arm      = bus.iw_arm;
  assign bus4.iw_stop     = bus.iw_stop;
  assign bus4.iw_mode     = bus.iw_mode;
  assign bus4.iw_trig_stg = bus.iw_trig_stg;
  assign bus4.iw_trig_pc  = bus.iw_trig_pc;
  assign bus4.iw_trig_opc = bus.iw_trig_opc;
  assign bus4.iw_post     = bus.iw_post;
  assign bus4.iw_rd_idx   = bus.iw_rd_idx;
  assign bus4.iw_rd_stg   = bus.iw_rd_stg;

  amber_trace_buf #(.NSTG(NSTG), .PC_W(PC_W), .OPC_W(OPC_W),
    .DEPTH(DEPTH), .TICK_W(16)) u_dut (
    .iw_clk(clk), .iw_rst(rst), .bus(bus.slave));

  amber_trace_buf #(.NSTG(NSTG), .PC_W(PC_W), .OPC_W(OPC_W),
    .DEPTH(DEPTH), .TICK_W(4)) u_dut4 (
    .iw_clk(clk), .iw_rst(rst), .bus(bus4.slave));

  typedef struct packed {
    logic [NSTG*PC_W-1:0]  pcs;
    logic [NSTG*OPC_W-1:0] opcs;
    logic [15:0]           tick;
  } ent_t;

  ent_t q[$];
  int mst, mleft, mtrig, mtick;
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mst = 0; mleft = 0; mtrig = -1; mtick = 0;
  endtask

  task automatic model_update();
    ent_t e;
    logic mhit;
    int stg;
    if (bus.iw_arm) begin
      q.delete();
      mtrig = -1;
      mst = 1;
    end else if (mst == 1 || mst == 2) begin
      e.pcs  = bus.iw_pc_bus;
      e.opcs = bus.iw_opc_bus;
      e.tick = 16'(mtick);
      q.push_back(e);
      if (q.size() > DEPTH) begin
        q.delete(0);
        if (mtrig >= 0) mtrig--;
      end
      if (mst == 1) begin
        stg = int'(bus.iw_trig_stg);
        mhit = (bus.iw_mode == 2'd1 &&
                bus.iw_pc_bus[stg*PC_W +: PC_W] == bus.iw_trig_pc) ||
               (bus.iw_mode == 2'd2 &&
                bus.iw_opc_bus[stg*OPC_W +: OPC_W] == bus.iw_trig_opc);
        if (mhit) begin
          mtrig = q.size() - 1;
          mleft = int'(bus.iw_post);
        end
        if (bus.iw_stop || (mhit && mleft == 0)) mst = 3;
        else if (mhit) mst = 2;
      end else begin
        mleft--;
        if (bus.iw_stop || mleft == 0) mst = 3;
      end
    end
    mtick = (mtick + 1) & 16'hFFFF;
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    chk("state", 32'(bus.ow_state), mst);
    chk("count", 32'(bus.ow_count), q.size());
    chk("tick", 32'(bus.ow_tick), mtick);
    chk("state4", 32'(bus4.ow_state), mst);
    chk("tick4", 32'(bus4.ow_tick), mtick & 15);
    if (mst == 3)
      chk("trig_idx", 32'(bus.ow_trig_idx), (mtrig < 0) ? 0 : mtrig);
  endtask

  task automatic rd(input int idx, input int stg);
    ent_t e;
    bus.iw_rd_idx = 5'(idx);
    bus.iw_rd_stg = 3'(stg);
    step();
    if (idx < q.size()) begin
      e = q[idx];
      chk("rd_pc", 32'(bus.ow_rd_pc), 32'(e.pcs[stg*PC_W +: PC_W]));
      chk("rd_opc", 32'(bus.ow_rd_opc), 32'(e.opcs[stg*OPC_W +: OPC_W]));
      chk("rd_tick", 32'(bus.ow_rd_tick), 32'(e.tick));
      chk("rd_tick4", 32'(bus4.ow_rd_tick), 32'(e.tick[3:0]));
    end
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) rd(i, $urandom_range(0, NSTG - 1));
  endtask

  task automatic rand_bus(input int lim);
    for (int s = 0; s < NSTG; s++) begin
      if (lim == 0) begin
        bus.iw_pc_bus[s*PC_W +: PC_W]    = PC_W'($urandom);
        bus.iw_opc_bus[s*OPC_W +: OPC_W] = OPC_W'($urandom);
      end else begin
        bus.iw_pc_bus[s*PC_W +: PC_W]    = PC_W'($urandom_range(0, lim));
        bus.iw_opc_bus[s*OPC_W +: OPC_W] = OPC_W'($urandom_range(0, lim));
      end
    end
  endtask

  task automatic arm_once();
    bus.iw_arm = 1'b1;
    rand_bus(0);
    step();
    bus.iw_arm = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    bus.iw_pc_bus   = '0;
    bus.iw_opc_bus  = '0;
    bus.iw_arm      = 1'b0;
    bus.iw_stop     = 1'b0;
    bus.iw_mode     = 2'd0;
    bus.iw_trig_stg = '0;
    bus.iw_trig_pc  = '0;
    bus.iw_trig_opc = '0;
    bus.iw_post     = '0;
    bus.iw_rd_idx   = '0;
    bus.iw_rd_stg   = '0;
    model_reset();
    #12;
    chk("rst_state", 32'(bus.ow_state), 0);
    chk("rst_count", 32'(bus.ow_count), 0);
    chk("rst_tick", 32'(bus.ow_tick), 0);
    chk("rst_trig_idx", 32'(bus.ow_trig_idx), 0);
    chk("rst_rd_pc", 32'(bus.ow_rd_pc), 0);
    chk("rst_rd_opc", 32'(bus.ow_rd_opc), 0);
    chk("rst_rd_tick", 32'(bus.ow_rd_tick), 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    step();

    // free-run, 40 captures, stop on the last
    bus.iw_mode = 2'd0;
    arm_once();
    for (int k = 1; k <= 40; k++) begin
      rand_bus(0);
      bus.iw_pc_bus[0 +: PC_W] = PC_W'(k);
      bus.iw_stop = (k == 40);
      step();
    end
    bus.iw_stop = 1'b0;
    chk("t1_count", 32'(bus.ow_count), 32);
    chk("t1_state", 32'(bus.ow_state), 3);
    rd(0, 0);
    chk("t1_idx0", 32'(bus.ow_rd_pc), 9);
    rd(31, 0);
    chk("t1_idx31", 32'(bus.ow_rd_pc), 40);
    read_all();

    // PC trigger in stage 4, five post entries
    bus.iw_mode     = 2'd1;
    bus.iw_trig_stg = 3'd4;
    bus.iw_trig_pc  = 24'h000123;
    bus.iw_post     = 5'd5;
    arm_once();
    for (int k = 1; k <= 26; k++) begin
      rand_bus(0);
      if (k == 21)
        bus.iw_pc_bus[4*PC_W +: PC_W] = 24'h000123;
      else if (bus.iw_pc_bus[4*PC_W +: PC_W] == 24'h000123)
        bus.iw_pc_bus[4*PC_W +: PC_W] = 24'h000124;
      step();
      if (k == 25) chk("t2_post", 32'(bus.ow_state), 2);
      if (k == 26) chk("t2_done", 32'(bus.ow_state), 3);
    end
    chk("t2_count", 32'(bus.ow_count), 26);
    chk("t2_trig_idx", 32'(bus.ow_trig_idx), 20);
    rd(int'(bus.ow_trig_idx), 4);
    chk("t2_trig_pc", 32'(bus.ow_rd_pc), 32'h000123);
    read_all();

    // opcode trigger with zero post
    bus.iw_mode     = 2'd2;
    bus.iw_trig_stg = 3'd2;
    bus.iw_trig_opc = 8'h2A;
    bus.iw_post     = 5'd0;
    arm_once();
    for (int k = 1; k <= 3; k++) begin
      rand_bus(0);
      if (k == 3)
        bus.iw_opc_bus[2*OPC_W +: OPC_W] = 8'h2A;
      else if (bus.iw_opc_bus[2*OPC_W +: OPC_W] == 8'h2A)
        bus.iw_opc_bus[2*OPC_W +: OPC_W] = 8'h2B;
      step();
    end
    chk("t3_state", 32'(bus.ow_state), 3);
    chk("t3_count", 32'(bus.ow_count), 3);
    chk("t3_trig_idx", 32'(bus.ow_trig_idx), 2);
    step();
    read_all();

    // arm together with a matching PC
    bus.iw_mode     = 2'd1;
    bus.iw_trig_stg = 3'd0;
    bus.iw_trig_pc  = 24'hABCDEF;
    bus.iw_post     = 5'd0;
    arm_once();
    bus.iw_pc_bus[0 +: PC_W] = 24'h000001;
    step();
    bus.iw_arm = 1'b1;
    bus.iw_pc_bus[0 +: PC_W] = 24'hABCDEF;
    step();
    bus.iw_arm = 1'b0;
    chk("t4_state", 32'(bus.ow_state), 1);
    chk("t4_count", 32'(bus.ow_count), 0);
    bus.iw_pc_bus[0 +: PC_W] = 24'h000002;
    step();
    chk("t4_next_state", 32'(bus.ow_state), 1);
    chk("t4_next_count", 32'(bus.ow_count), 1);
    bus.iw_stop = 1'b1;
    step();
    bus.iw_stop = 1'b0;

    // reset in the middle of POST
    bus.iw_trig_stg = 3'd1;
    bus.iw_trig_pc  = 24'h00BEEF;
    bus.iw_post     = 5'd20;
    arm_once();
    for (int k = 1; k <= 7; k++) begin
      rand_bus(0);
      bus.iw_pc_bus[1*PC_W +: PC_W] = (k == 4) ? 24'h00BEEF : 24'h0;
      step();
    end
    chk("t5_in_post", 32'(bus.ow_state), 2);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_state", 32'(bus.ow_state), 0);
    chk("t5_rst_tick", 32'(bus.ow_tick), 0);
    chk("t5_rst_count", 32'(bus.ow_count), 0);
    chk("t5_rst_tick4", 32'(bus4.ow_tick), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.iw_mode = 2'd0;
    arm_once();
    for (int k = 0; k < 10; k++) begin
      rand_bus(0);
      step();
    end
    bus.iw_stop = 1'b1;
    step();
    bus.iw_stop = 1'b0;
    chk("t5_rearm_count", 32'(bus.ow_count), 11);
    read_all();

    // randomized runs with a narrow value space so triggers hit
    for (int r = 0; r < 6; r++) begin
      bus.iw_mode     = 2'($urandom_range(0, 3));
      bus.iw_trig_stg = 3'($urandom_range(0, NSTG - 1));
      bus.iw_trig_pc  = 24'($urandom_range(0, 3));
      bus.iw_trig_opc = 8'($urandom_range(0, 3));
      bus.iw_post     = 5'($urandom_range(0, 31));
      arm_once();
      for (int c = 0; c < 100; c++) begin
        rand_bus(($urandom_range(0, 3) == 0) ? 3 : 15);
        bus.iw_stop = ($urandom_range(0, 49) == 0);
        bus.iw_arm  = ($urandom_range(0, 79) == 0);
        if ($urandom_range(0, 19) == 0)
          bus.iw_mode = 2'($urandom_range(0, 3));
        step();
      end
      bus.iw_arm  = 1'b0;
      bus.iw_stop = 1'b1;
      step();
      bus.iw_stop = 1'b0;
      read_all();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
